// File: rtl/id_stage.sv
// rtl/id_stage.sv - dual-issue RV32I decode stage with forwarding, stall detection and register file
module id_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr1,
  input  logic [31:0]       instr2,
  input  logic [127:0]      ID_EX,
  input  logic [17:0]       EX_MEM,
  input  logic [17:0]       MEM_WB,
  input  logic [4:0]        rd1,
  input  logic [4:0]        rd2,
  input  logic [XLEN-1:0]   wb_data1,
  input  logic [XLEN-1:0]   wb_data2,
  input  logic [3:0]        wb_we1,
  input  logic [3:0]        wb_we2,
  output logic [127:0]      ID_out,
  output logic [23:0]       cntrl,
  output logic [13:0]       haz,
  output logic [4*XLEN-1:0] datas
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [3:0] WB_REG  = 4'd2;

  // Raw fields plus the packed immediate fields used downstream.
  function automatic logic [63:0] f_decode(input logic [31:0] ins);
    logic [11:0] imm12;
    logic [19:0] imm20;
    case (ins[6:0])
      OP_I, OP_LD, OP_JALR: imm12 = ins[31:20];
      OP_ST:                imm12 = {ins[31:25], ins[11:7]};
      OP_BR:                imm12 = {ins[31], ins[7], ins[30:25], ins[11:8]};
      default:              imm12 = 12'd0;
    endcase
    case (ins[6:0])
      OP_LUI, OP_AUI: imm20 = ins[31:12];
      OP_JAL:         imm20 = {ins[31], ins[19:12], ins[20], ins[30:21]};
      default:        imm20 = 20'd0;
    endcase
    return {ins[6:0], ins[11:7], ins[14:12], ins[19:15], ins[24:20], ins[31:25], imm12, imm20};
  endfunction

  // {alu_src, mem_rd, mem_wr, branch, jump, alu_op[3], wb[4]}
  function automatic logic [11:0] f_ctrl(input logic [6:0] op);
    case (op)
      OP_R:           return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, WB_REG};
      OP_I:           return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, WB_REG};
      OP_LD:          return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, WB_REG};
      OP_ST:          return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
      OP_BR:          return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 4'd0};
      OP_LUI, OP_AUI: return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, WB_REG};
      OP_JAL:         return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, WB_REG};
      OP_JALR:        return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, WB_REG};
      default:        return 12'd0;
    endcase
  endfunction

  // A later-stage {rd, cntrl} entry that will write the register being read.
  function automatic logic f_match(input logic [8:0] rc, input logic [4:0] rs);
    return (rc[3:0] == WB_REG) && (rc[8:4] != 5'd0) && (rc[8:4] == rs);
  endfunction

  // Youngest producer wins: lane B of a bundle is younger than lane A.
  function automatic logic [2:0] f_fwd(input logic [4:0] rs, input logic [17:0] exm,
                                       input logic [17:0] mwb);
    if (f_match(exm[8:0], rs))       return 3'd2;
    else if (f_match(exm[17:9], rs)) return 3'd1;
    else if (f_match(mwb[8:0], rs))  return 3'd4;
    else if (f_match(mwb[17:9], rs)) return 3'd3;
    else                             return 3'd0;
  endfunction

  // Load in EX whose result is not available in time for this consumer.
  function automatic logic f_ld_hit(input logic [6:0] op, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2);
    return (op == OP_LD) && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  logic [63:0] w_id_a, w_id_b;
  logic [11:0] w_ctrl_a, w_ctrl_b;
  logic        w_stall_a, w_stall_b, w_intra;
  logic        w_we1, w_we2;
  logic        w_unused_id_ex;

  assign w_id_a   = f_decode(instr1);
  assign w_id_b   = f_decode(instr2);
  assign w_ctrl_a = f_ctrl(instr1[6:0]);
  assign w_ctrl_b = f_ctrl(instr2[6:0]);
  assign ID_out   = {w_id_a, w_id_b};
  assign cntrl    = {w_ctrl_a, w_ctrl_b};

  assign w_stall_a = f_ld_hit(ID_EX[127:121], ID_EX[120:116], w_id_a[48:44], w_id_a[43:39])
                   | f_ld_hit(ID_EX[63:57],   ID_EX[56:52],   w_id_a[48:44], w_id_a[43:39]);
  assign w_intra   = (w_ctrl_a[3:0] == WB_REG) && (w_id_a[56:52] != 5'd0)
                   && ((w_id_a[56:52] == w_id_b[48:44]) || (w_id_a[56:52] == w_id_b[43:39]));
  assign w_stall_b = w_stall_a | w_intra
                   | f_ld_hit(ID_EX[127:121], ID_EX[120:116], w_id_b[48:44], w_id_b[43:39])
                   | f_ld_hit(ID_EX[63:57],   ID_EX[56:52],   w_id_b[48:44], w_id_b[43:39]);

  assign haz = {f_fwd(ID_EX[112:108], EX_MEM, MEM_WB), f_fwd(ID_EX[107:103], EX_MEM, MEM_WB),
                w_stall_a,
                f_fwd(ID_EX[48:44], EX_MEM, MEM_WB), f_fwd(ID_EX[43:39], EX_MEM, MEM_WB),
                w_stall_b};

  // funct3 / funct7 / immediates of the EX bundle play no part in hazard detection.
  assign w_unused_id_ex = ^{ID_EX[115:113], ID_EX[102:64], ID_EX[51:49], ID_EX[38:0]};

  // Port 1 wins a same-register collision, so port 2 is simply suppressed.
  assign w_we1 = (wb_we1 == WB_REG) && (rd1 != 5'd0);
  assign w_we2 = (wb_we2 == WB_REG) && (rd2 != 5'd0) && !(w_we1 && (rd1 == rd2));

  logic [XLEN-1:0] r_regs [NREG];

  // Register file write ports; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (w_we1) r_regs[rd1] <= wb_data1;
      if (w_we2) r_regs[rd2] <= wb_data2;
    end
  end

  logic [4:0]      w_raddr [4];
  logic [XLEN-1:0] w_rdata [4];

  assign w_raddr[0] = w_id_a[48:44];
  assign w_raddr[1] = w_id_a[43:39];
  assign w_raddr[2] = w_id_b[48:44];
  assign w_raddr[3] = w_id_b[43:39];

  // Asynchronous reads with write-first bypass of the winning write-back data.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_rdata[i] = r_regs[w_raddr[i]];
      if (w_raddr[i] == 5'd0)                  w_rdata[i] = '0;
      else if (w_we1 && (rd1 == w_raddr[i]))   w_rdata[i] = wb_data1;
      else if (w_we2 && (rd2 == w_raddr[i]))   w_rdata[i] = wb_data2;
    end
  end

  assign datas = {w_rdata[0], w_rdata[1], w_rdata[2], w_rdata[3]};

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard testbench for id_stage against an ISA-level reference model
module tb_id_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  instr1, instr2;
  logic [127:0] ID_EX;
  logic [17:0]  EX_MEM, MEM_WB;
  logic [4:0]   rd1, rd2;
  logic [31:0]  wb_data1, wb_data2;
  logic [3:0]   wb_we1, wb_we2;
  logic [127:0] ID_out;
  logic [23:0]  cntrl;
  logic [13:0]  haz;
  logic [127:0] datas;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .instr1(instr1), .instr2(instr2),
    .ID_EX(ID_EX), .EX_MEM(EX_MEM), .MEM_WB(MEM_WB),
    .rd1(rd1), .rd2(rd2), .wb_data1(wb_data1), .wb_data2(wb_data2),
    .wb_we1(wb_we1), .wb_we2(wb_we2),
    .ID_out(ID_out), .cntrl(cntrl), .haz(haz), .datas(datas)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] id;
    logic [23:0]  c;
    logic [13:0]  h;
    logic [127:0] d;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] m_regs [32];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Immediates built as full ISA values, then narrowed to the stored field.
  function automatic logic [63:0] m_decode(input logic [31:0] ins);
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [11:0] f12;
    logic [19:0] f20;
    i_imm = {{20{ins[31]}}, ins[31:20]};
    s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    u_imm = {ins[31:12], 12'b0};
    j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    f12 = 12'd0;
    f20 = 20'd0;
    if (ins[6:0] == 7'h13 || ins[6:0] == 7'h03 || ins[6:0] == 7'h67) f12 = i_imm[11:0];
    if (ins[6:0] == 7'h23) f12 = s_imm[11:0];
    if (ins[6:0] == 7'h63) f12 = b_imm[12:1];
    if (ins[6:0] == 7'h37 || ins[6:0] == 7'h17) f20 = u_imm[31:12];
    if (ins[6:0] == 7'h6f) f20 = j_imm[20:1];
    return {ins[6:0], ins[11:7], ins[14:12], ins[19:15], ins[24:20], ins[31:25], f12, f20};
  endfunction

  function automatic logic [11:0] m_ctrl(input logic [6:0] op);
    logic is_r, is_i, is_ld, is_st, is_br, is_u, is_jal, is_jalr, writes, alu_src;
    logic [2:0] aop;
    is_r    = (op == 7'h33);
    is_i    = (op == 7'h13);
    is_ld   = (op == 7'h03);
    is_st   = (op == 7'h23);
    is_br   = (op == 7'h63);
    is_u    = (op == 7'h37) || (op == 7'h17);
    is_jal  = (op == 7'h6f);
    is_jalr = (op == 7'h67);
    writes  = is_r | is_i | is_ld | is_u | is_jal | is_jalr;
    alu_src = is_i | is_ld | is_st | is_jalr | is_u;
    aop     = is_r ? 3'd1 : is_i ? 3'd2 : is_br ? 3'd3 : 3'd0;
    return {alu_src, is_ld, is_st, is_br, is_jal | is_jalr, aop, writes ? 4'd2 : 4'd0};
  endfunction

  function automatic logic [2:0] m_fwd(input logic [4:0] rs, input logic [17:0] exm,
                                       input logic [17:0] mwb);
    logic [8:0] src [4];
    logic [2:0] code [4];
    src[0] = exm[8:0];  code[0] = 3'd2;
    src[1] = exm[17:9]; code[1] = 3'd1;
    src[2] = mwb[8:0];  code[2] = 3'd4;
    src[3] = mwb[17:9]; code[3] = 3'd3;
    for (int k = 0; k < 4; k++)
      if (src[k][3:0] == 4'd2 && src[k][8:4] != 5'd0 && src[k][8:4] == rs) return code[k];
    return 3'd0;
  endfunction

  function automatic logic m_load_dep(input logic [31:0] ins, input logic [127:0] idex);
    logic [63:0] lane;
    logic hit;
    hit = 1'b0;
    for (int l = 0; l < 2; l++) begin
      lane = (l == 0) ? idex[127:64] : idex[63:0];
      if (lane[63:57] == 7'h03 && lane[56:52] != 5'd0 &&
          (lane[56:52] == ins[19:15] || lane[56:52] == ins[24:20])) hit = 1'b1;
    end
    return hit;
  endfunction

  // Reference for the current inputs; regfile reads see the post-write state.
  task automatic push_expect();
    exp_t        e;
    logic [31:0] nx [32];
    logic [11:0] ca, cb;
    logic        sa, sb;
    if (!rst_n) for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
    nx = m_regs;
    if (rst_n && wb_we2 == 4'd2 && rd2 != 5'd0) nx[rd2] = wb_data2;
    if (rst_n && wb_we1 == 4'd2 && rd1 != 5'd0) nx[rd1] = wb_data1;
    ca = m_ctrl(instr1[6:0]);
    cb = m_ctrl(instr2[6:0]);
    sa = m_load_dep(instr1, ID_EX);
    sb = sa || m_load_dep(instr2, ID_EX) ||
         (ca[3:0] == 4'd2 && instr1[11:7] != 5'd0 &&
          (instr1[11:7] == instr2[19:15] || instr1[11:7] == instr2[24:20]));
    e.id = {m_decode(instr1), m_decode(instr2)};
    e.c  = {ca, cb};
    e.h  = {m_fwd(ID_EX[112:108], EX_MEM, MEM_WB), m_fwd(ID_EX[107:103], EX_MEM, MEM_WB), sa,
            m_fwd(ID_EX[48:44], EX_MEM, MEM_WB), m_fwd(ID_EX[43:39], EX_MEM, MEM_WB), sb};
    e.d  = {nx[instr1[19:15]], nx[instr1[24:20]], nx[instr2[19:15]], nx[instr2[24:20]]};
    q.push_back(e);
    if (rst_n) m_regs = nx;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr1 = 32'd0; instr2 = 32'd0; ID_EX = 128'd0; EX_MEM = 18'd0; MEM_WB = 18'd0;
    rd1 = 5'd0; rd2 = 5'd0; wb_data1 = 32'd0; wb_data2 = 32'd0; wb_we1 = 4'd0; wb_we2 = 4'd0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 9))
      0: ins[6:0] = 7'h33;
      1: ins[6:0] = 7'h13;
      2: ins[6:0] = 7'h03;
      3: ins[6:0] = 7'h23;
      4: ins[6:0] = 7'h63;
      5: ins[6:0] = 7'h37;
      6: ins[6:0] = 7'h17;
      7: ins[6:0] = 7'h6f;
      8: ins[6:0] = 7'h67;
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0) begin
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
    end
    return ins;
  endfunction

  function automatic logic [63:0] rand_ex_lane();
    logic [63:0] l;
    l = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 0) l[63:57] = 7'h03;
    l[56:52] = 5'($urandom_range(0, 7));
    l[48:44] = 5'($urandom_range(0, 7));
    l[43:39] = 5'($urandom_range(0, 7));
    return l;
  endfunction

  function automatic logic [8:0] rand_rc();
    logic [3:0] c;
    c = ($urandom_range(0, 4) < 3) ? 4'd2 : 4'($urandom);
    return {5'($urandom_range(0, 7)), c};
  endfunction

  // Monitor: outputs are combinational, so each driven cycle is sampled at the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("id_out", ID_out, e.id);
        chk("cntrl", {104'd0, cntrl}, {104'd0, e.c});
        chk("haz", {114'd0, haz}, {114'd0, e.h});
        chk("datas", datas, e.d);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    instr1 = 32'h00500093;
    push_expect(); #2;
    chk("addi_idA", {64'd0, ID_out[127:64]},
        {64'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd5, 7'd0, 12'd5, 20'd0});
    chk("addi_ctrlA", {116'd0, cntrl[23:12]}, 128'h822);
    chk("reset_read", {96'd0, datas[127:96]}, 128'd0);

    step(); clear_inputs();
    instr1 = 32'h00018093; wb_we1 = 4'd2; rd1 = 5'd3; wb_data1 = 32'hDEADBEEF;
    push_expect(); #2;
    chk("bypass_same_cycle", {96'd0, datas[127:96]}, 128'hDEADBEEF);
    step(); wb_we1 = 4'd0;
    push_expect(); #2;
    chk("written_next_cycle", {96'd0, datas[127:96]}, 128'hDEADBEEF);

    step(); clear_inputs();
    rd1 = 5'd5; rd2 = 5'd5; wb_we1 = 4'd2; wb_we2 = 4'd2;
    wb_data1 = 32'h11; wb_data2 = 32'h22; instr1 = 32'h00028093;
    push_expect(); #2;
    chk("dual_bypass_port1", {96'd0, datas[127:96]}, 128'h11);
    step(); clear_inputs(); instr1 = 32'h00028093;
    push_expect(); #2;
    chk("dual_write_port1", {96'd0, datas[127:96]}, 128'h11);
    step(); clear_inputs();
    rd1 = 5'd0; wb_we1 = 4'd2; wb_data1 = 32'h99; instr1 = 32'h00500093;
    push_expect(); #2;
    chk("x0_bypass", {96'd0, datas[127:96]}, 128'd0);
    step(); clear_inputs();
    push_expect(); #2;
    chk("x0_kept", {96'd0, datas[127:96]}, 128'd0);

    step(); clear_inputs();
    ID_EX[112:108] = 5'd7; EX_MEM[17:9] = {5'd7, 4'd2}; MEM_WB[8:0] = {5'd7, 4'd2};
    push_expect(); #2;
    chk("fwdA_exmem_a", {125'd0, haz[13:11]}, 128'd1);
    step(); EX_MEM[12:9] = 4'd0;
    push_expect(); #2;
    chk("fwdA_memwb_b", {125'd0, haz[13:11]}, 128'd4);

    step(); clear_inputs();
    ID_EX[63:57] = 7'h03; ID_EX[56:52] = 5'd9; instr1 = 32'h00500093; instr2 = 32'h009000B3;
    push_expect(); #2;
    chk("load_stallB", {127'd0, haz[0]}, 128'd1);
    chk("load_stallA", {127'd0, haz[7]}, 128'd0);

    step(); clear_inputs();
    instr1 = 32'h00208233; instr2 = 32'h40520333;
    push_expect(); #2;
    chk("intra_stallB", {127'd0, haz[0]}, 128'd1);
    step(); instr1 = 32'h00208223;
    push_expect(); #2;
    chk("store_stallB", {127'd0, haz[0]}, 128'd0);
    chk("store_wbA", {124'd0, cntrl[15:12]}, 128'd0);
    chk("store_memwrA", {127'd0, cntrl[21]}, 128'd1);

    for (int n = 0; n < 400; n++) begin
      step();
      instr1 = rand_instr();
      instr2 = rand_instr();
      ID_EX  = {rand_ex_lane(), rand_ex_lane()};
      EX_MEM = {rand_rc(), rand_rc()};
      MEM_WB = {rand_rc(), rand_rc()};
      rd1 = 5'($urandom_range(0, 7));
      rd2 = ($urandom_range(0, 3) == 0) ? rd1 : 5'($urandom_range(0, 7));
      wb_data1 = $urandom; wb_data2 = $urandom;
      wb_we1 = ($urandom_range(0, 4) < 3) ? 4'd2 : 4'($urandom);
      wb_we2 = ($urandom_range(0, 4) < 3) ? 4'd2 : 4'($urandom);
      rst_n = 1'b1;
      if (n == 200) begin
        rst_n = 1'b0; wb_we1 = 4'd0; wb_we2 = 4'd0;
      end
      push_expect();
    end

    step(); clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", 128'(q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
